// File: rtl/melody_pkg.sv
// Note codes, tone frequencies and the stored melody ROM shared by the melody player.
package melody_pkg;

  typedef logic [4:0] note_t;

  localparam note_t NoteRest = 5'd0;
  localparam note_t NoteC4   = 5'd1;
  localparam note_t NoteD4   = 5'd2;
  localparam note_t NoteE4   = 5'd3;
  localparam note_t NoteF4   = 5'd4;
  localparam note_t NoteG4   = 5'd5;
  localparam note_t NoteA4   = 5'd6;
  localparam note_t NoteB4   = 5'd7;
  localparam note_t NoteC5   = 5'd8;
  localparam note_t NoteD5   = 5'd9;
  localparam note_t NoteE5   = 5'd10;
  localparam note_t NoteF5   = 5'd11;
  localparam note_t NoteG5   = 5'd12;
  localparam note_t NoteA5   = 5'd13;
  localparam note_t NoteB5   = 5'd14;
  localparam note_t NoteC6   = 5'd15;
  localparam note_t NoteD6   = 5'd16;
  localparam note_t NoteE6   = 5'd17;
  localparam note_t NoteF6   = 5'd18;
  localparam note_t NoteG6   = 5'd19;
  localparam note_t NoteA6   = 5'd20;
  localparam note_t NoteB6   = 5'd21;
  localparam note_t NoteEnd  = 5'd31;

  function automatic logic is_tone(input note_t code);
    return (code >= NoteC4) && (code <= NoteB6);
  endfunction

  // Tone frequency table in Hz; non-tone codes map to 0.
  function automatic int unsigned note_freq(input note_t code);
    case (code)
      NoteC4: return 262;  NoteD4: return 294;  NoteE4: return 330;  NoteF4: return 349;
      NoteG4: return 392;  NoteA4: return 440;  NoteB4: return 494;
      NoteC5: return 523;  NoteD5: return 587;  NoteE5: return 659;  NoteF5: return 698;
      NoteG5: return 784;  NoteA5: return 880;  NoteB5: return 988;
      NoteC6: return 1047; NoteD6: return 1175; NoteE6: return 1319; NoteF6: return 1397;
      NoteG6: return 1568; NoteA6: return 1760; NoteB6: return 1976;
      default: return 0;
    endcase
  endfunction

  function automatic int unsigned half_period(input note_t code, input int unsigned clk_hz);
    if (!is_tone(code)) return 0;
    return clk_hz / (2 * note_freq(code));
  endfunction

  function automatic note_t song_note(input int unsigned id, input int unsigned idx);
    note_t n;
    n = NoteEnd;
    case (id)
      0: if (idx < 8) n = NoteA4;
      1: begin
        case (idx)
          0:       n = NoteC4;
          1:       n = NoteRest;
          default: n = NoteEnd;
        endcase
      end
      2: begin
        case (idx)
          0:       n = NoteE4;
          1:       n = NoteE4;
          2:       n = NoteG4;
          3:       n = NoteRest;
          4:       n = NoteC5;
          5:       n = 5'd25; // reserved code, sounds as a rest
          6:       n = NoteB6;
          7:       n = NoteC4;
          default: n = NoteEnd;
        endcase
      end
      default: n = NoteEnd;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/tone_gen.sv
// Square-wave generator: phase counter toggling audio every half-period of the current note.
module tone_gen
  import melody_pkg::*;
#(
  parameter int unsigned CLK_HZ = 100000000
) (
  input  logic       sys_CLK,
  input  logic       rst,
  input  logic [4:0] note,
  input  logic       restart,
  output logic       audio
);

  localparam int unsigned HpMax = half_period(NoteC4, CLK_HZ);
  localparam int unsigned PH_W  = (HpMax > 1) ? $clog2(HpMax) : 1;

  logic [PH_W-1:0] ph_q, ph_d, hp_last;
  logic            audio_q, audio_d;

  always_comb begin
    hp_last = PH_W'(half_period(note, CLK_HZ) - 1);
    ph_d    = ph_q;
    audio_d = audio_q;
    if (restart || !is_tone(note)) begin
      ph_d    = '0;
      audio_d = 1'b0;
    end else if (ph_q == hp_last) begin
      ph_d    = '0;
      audio_d = ~audio_q;
    end else begin
      ph_d = ph_q + PH_W'(1);
    end
  end

  always_ff @(posedge sys_CLK or posedge rst) begin
    if (rst) begin
      ph_q    <= '0;
      audio_q <= 1'b0;
    end else begin
      ph_q    <= ph_d;
      audio_q <= audio_d;
    end
  end

  assign audio = audio_q;

endmodule

// File: rtl/melody_player.sv
// Melody sequencer: play/stop/loop FSM, tempo tick and step counter driving a tone generator.
module melody_player
  import melody_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 100000000,
  parameter int unsigned TEMPO_HZ  = 4,
  parameter int unsigned NUM_SONGS = 4,
  parameter int unsigned SONG_LEN  = 64,
  localparam int unsigned SID_W    = (NUM_SONGS > 1) ? $clog2(NUM_SONGS) : 1,
  localparam int unsigned STEP_W   = (SONG_LEN > 1) ? $clog2(SONG_LEN) : 1
) (
  input  logic              sys_CLK,
  input  logic              rst,
  input  logic              play,
  input  logic [SID_W-1:0]  song_id,
  input  logic              loop_en,
  output logic              audio,
  output logic              busy,
  output logic              done,
  output logic [STEP_W-1:0] step,
  output logic [4:0]        note
);

  localparam int unsigned TICK_DIV = CLK_HZ / TEMPO_HZ;
  localparam int unsigned TICK_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [TICK_W-1:0] TickLast = TICK_W'(TICK_DIV - 1);
  localparam logic [STEP_W:0]   StepEnd  = (STEP_W + 1)'(SONG_LEN);
  localparam logic [SID_W:0]    IdLimit  = (SID_W + 1)'(NUM_SONGS);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StPlay = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [SID_W-1:0]  id_q, id_d;
  logic [STEP_W-1:0] step_q, step_d;
  note_t             note_q, note_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic              done_q, done_d;

  logic [STEP_W:0] next_idx;
  note_t           next_note, first_note, loop_note;
  logic            at_end, id_ok, song_chg, restart;

  always_comb begin
    next_idx   = {1'b0, step_q} + {{STEP_W{1'b0}}, 1'b1};
    next_note  = song_note(32'(id_q), 32'(next_idx));
    loop_note  = song_note(32'(id_q), 0);
    first_note = song_note(32'(song_id), 0);
    at_end     = (next_idx == StepEnd) || (next_note == NoteEnd);
    id_ok      = ({1'b0, song_id} < IdLimit);
  end

  // Priority inside PLAY: stop, then song change, then step advance.
  always_comb begin
    state_d  = state_q;
    id_d     = id_q;
    step_d   = step_q;
    note_d   = note_q;
    tick_d   = tick_q;
    done_d   = 1'b0;
    song_chg = 1'b0;
    case (state_q)
      StIdle: begin
        if (play) begin
          id_d   = song_id;
          step_d = '0;
          tick_d = '0;
          if (id_ok) begin
            note_d  = first_note;
            state_d = StPlay;
          end else begin
            state_d = StDone;
            done_d  = 1'b1;
          end
        end
      end
      StPlay: begin
        if (!play) begin
          state_d = StIdle;
        end else if (song_id != id_q) begin
          song_chg = 1'b1;
          id_d     = song_id;
          step_d   = '0;
          tick_d   = '0;
          if (id_ok) begin
            note_d = first_note;
          end else begin
            state_d = StDone;
            done_d  = 1'b1;
          end
        end else if (tick_q == TickLast) begin
          tick_d = '0;
          if (!at_end) begin
            step_d = next_idx[STEP_W-1:0];
            note_d = next_note;
          end else if (loop_en) begin
            step_d = '0;
            note_d = loop_note;
          end else begin
            state_d = StDone;
            done_d  = 1'b1;
          end
        end else begin
          tick_d = tick_q + TICK_W'(1);
        end
      end
      StDone: begin
        if (!play) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Phase restarts whenever the tone is not continuing unchanged through this edge.
  assign restart = (state_q != StPlay) || (state_d != StPlay) || (note_d != note_q) || song_chg;

  always_ff @(posedge sys_CLK or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      id_q    <= '0;
      step_q  <= '0;
      note_q  <= NoteRest;
      tick_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      step_q  <= step_d;
      note_q  <= note_d;
      tick_q  <= tick_d;
      done_q  <= done_d;
    end
  end

  tone_gen #(
    .CLK_HZ (CLK_HZ)
  ) u_tone_gen (
    .sys_CLK (sys_CLK),
    .rst     (rst),
    .note    (note_q),
    .restart (restart),
    .audio   (audio)
  );

  assign busy = (state_q == StPlay);
  assign done = done_q;
  assign step = step_q;
  assign note = note_q;

endmodule

// File: tb/tb_melody_player.sv
// Directed and randomized bench for melody_player against a time-based reference model.
module tb_melody_player;

  localparam int unsigned CLK_HZ    = 1000000;
  localparam int unsigned TEMPO_HZ  = 1000;
  localparam int unsigned NUM_SONGS = 4;
  localparam int unsigned SONG_LEN  = 8;
  localparam int unsigned TICK_DIV  = CLK_HZ / TEMPO_HZ;

  logic       sys_CLK = 1'b0;
  logic       rst, play, loop_en;
  logic [1:0] song_id;
  logic       audio, busy, done;
  logic [2:0] step;
  logic [4:0] note;

  always #5 sys_CLK = ~sys_CLK;

  melody_player #(
    .CLK_HZ    (CLK_HZ),
    .TEMPO_HZ  (TEMPO_HZ),
    .NUM_SONGS (NUM_SONGS),
    .SONG_LEN  (SONG_LEN)
  ) dut (
    .sys_CLK (sys_CLK),
    .rst     (rst),
    .play    (play),
    .song_id (song_id),
    .loop_en (loop_en),
    .audio   (audio),
    .busy    (busy),
    .done    (done),
    .step    (step),
    .note    (note)
  );

  int freq_tab [22] = '{0, 262, 294, 330, 349, 392, 440, 494, 523, 587, 659, 698, 784, 880, 988,
                        1047, 1175, 1319, 1397, 1568, 1760, 1976};
  int song_tab [4][8] = '{'{6, 6, 6, 6, 6, 6, 6, 6},
                          '{1, 0, 31, 31, 31, 31, 31, 31},
                          '{3, 3, 5, 0, 8, 25, 21, 1},
                          '{31, 31, 31, 31, 31, 31, 31, 31}};

  int unsigned tests = 0;
  int unsigned fails = 0;

  // Model: 0 idle, 1 play, 2 done; times are edge counts.
  int    m_st, m_id, m_step, m_note;
  bit    m_done;
  longint n, m_step_t0, m_ph_t0;
  int    done_cnt;
  longint done_at, start_n;

  task automatic model_reset();
    m_st = 0; m_id = 0; m_step = 0; m_note = 0; m_done = 0;
  endtask

  function automatic bit exp_audio();
    longint h;
    if (m_st != 1 || m_note < 1 || m_note > 21) return 1'b0;
    h = longint'(CLK_HZ / (2 * freq_tab[m_note]));
    return (((n - m_ph_t0) / h) % 2) == 1;
  endfunction

  task automatic set_note(input int nn);
    if (nn != m_note) m_ph_t0 = n;
    m_note = nn;
  endtask

  task automatic model_edge();
    int nxt;
    n++;
    m_done = 1'b0;
    case (m_st)
      0: if (play) begin
        m_id = int'(song_id); m_step = 0; m_step_t0 = n; m_ph_t0 = n;
        m_note = song_tab[m_id][0]; m_st = 1;
      end
      1: if (!play) begin
        m_st = 0;
      end else if (int'(song_id) != m_id) begin
        m_id = int'(song_id); m_step = 0; m_step_t0 = n; m_ph_t0 = n;
        m_note = song_tab[m_id][0];
      end else if (n - m_step_t0 == longint'(TICK_DIV)) begin
        m_step_t0 = n;
        nxt = m_step + 1;
        if (nxt < SONG_LEN && song_tab[m_id][nxt % SONG_LEN] != 31) begin
          m_step = nxt;
          set_note(song_tab[m_id][nxt]);
        end else if (loop_en) begin
          m_step = 0;
          set_note(song_tab[m_id][0]);
        end else begin
          m_st = 2; m_done = 1'b1;
        end
      end
      default: if (!play) m_st = 0;
    endcase
  endtask

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    assert (act === expv) else begin
      fails++;
      $error("FAIL %s: got %0d, want %0d", tag, act, expv);
    end
  endtask

  task automatic check_outs();
    logic [10:0] act, expv;
    act  = {audio, busy, done, step, note};
    expv = {exp_audio(), (m_st == 1), m_done, 3'(m_step), 5'(m_note)};
    tests++;
    assert (act === expv) else begin
      fails++;
      $error("FAIL outs @%0d: got a=%0b b=%0b d=%0b s=%0d n=%0d want a=%0b b=%0b d=%0b s=%0d n=%0d",
             n, act[10], act[9], act[8], act[7:5], act[4:0],
             expv[10], expv[9], expv[8], expv[7:5], expv[4:0]);
    end
    if (done === 1'b1) begin
      done_cnt++;
      done_at = n;
    end
  endtask

  task automatic run(input int k);
    for (int i = 0; i < k; i++) begin
      @(posedge sys_CLK);
      model_edge();
      @(negedge sys_CLK);
      check_outs();
    end
  endtask

  initial begin
    rst = 1'b0; play = 1'b0; loop_en = 1'b0; song_id = 2'd0;
    n = 0; m_step_t0 = 0; m_ph_t0 = 0; done_cnt = 0; done_at = 0; start_n = 0;
    model_reset();
    #3 rst = 1'b1;
    #1;
    check("rst_audio", 32'(audio), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_step", 32'(step), 0);
    check("rst_note", 32'(note), 0);
    repeat (2) @(negedge sys_CLK);
    rst = 1'b0;
    run(3);

    // Song 0, no loop: legato A4 for 8 steps then one done pulse.
    song_id = 2'd0; loop_en = 1'b0; play = 1'b1; done_cnt = 0; start_n = n + 1;
    run(1);
    check("s1_busy", 32'(busy), 1);
    run(8 * TICK_DIV + 4);
    check("s1_done_cnt", 32'(done_cnt), 1);
    check("s1_done_at", 32'(done_at - start_n), 8 * TICK_DIV);
    check("s1_busy_end", 32'(busy), 0);
    check("s1_audio_end", 32'(audio), 0);
    play = 1'b0;
    run(2);

    // Song 1 ends early on END.
    song_id = 2'd1; play = 1'b1; done_cnt = 0; start_n = n + 1;
    run(2 * TICK_DIV + 3);
    check("s2_done_cnt", 32'(done_cnt), 1);
    check("s2_done_at", 32'(done_at - start_n), 2 * TICK_DIV);
    play = 1'b0;
    run(2);

    // Looping: three full passes, never done.
    song_id = 2'd0; loop_en = 1'b1; play = 1'b1; done_cnt = 0;
    run(1 + 3 * 8 * TICK_DIV);
    check("s3_done_cnt", 32'(done_cnt), 0);
    check("s3_busy", 32'(busy), 1);
    play = 1'b0;
    run(2);
    check("s3_stop_busy", 32'(busy), 0);

    // Song change mid-step.
    loop_en = 1'b0; song_id = 2'd0; play = 1'b1;
    run(1 + TICK_DIV + 437);
    done_cnt = 0;
    song_id = 2'd2;
    run(1);
    check("s4_step", 32'(step), 0);
    check("s4_audio", 32'(audio), 0);
    check("s4_note", 32'(note), 3);
    check("s4_busy", 32'(busy), 1);
    check("s4_no_done", 32'(done_cnt), 0);
    run(8 * TICK_DIV + 3);
    check("s4_done_cnt", 32'(done_cnt), 1);
    play = 1'b0;
    run(2);

    // Stop at step 3, then replay from step 0.
    song_id = 2'd0; play = 1'b1;
    run(1 + 3 * TICK_DIV + 100);
    check("s5_step3", 32'(step), 3);
    play = 1'b0;
    run(1);
    check("s5_busy", 32'(busy), 0);
    check("s5_audio", 32'(audio), 0);
    check("s5_step_hold", 32'(step), 3);
    run(5);
    play = 1'b1;
    run(1);
    check("s5_restart_step", 32'(step), 0);
    check("s5_restart_busy", 32'(busy), 1);

    // Async reset while audio is high.
    run(1200);
    check("s6_audio_hi", 32'(audio), 1);
    #1 rst = 1'b1;
    #1;
    check("s6_rst_audio", 32'(audio), 0);
    check("s6_rst_busy", 32'(busy), 0);
    check("s6_rst_step", 32'(step), 0);
    model_reset();
    play = 1'b0;
    @(negedge sys_CLK);
    rst = 1'b0;
    run(2);

    // Empty song: done at the first tick.
    song_id = 2'd3; play = 1'b1; done_cnt = 0; start_n = n + 1;
    run(1 + TICK_DIV + 3);
    check("s6_empty_done", 32'(done_cnt), 1);
    check("s6_empty_at", 32'(done_at - start_n), TICK_DIV);
    play = 1'b0;
    run(2);

    // Randomized control sequences.
    for (int s = 0; s < 12; s++) begin
      play    = ($urandom_range(0, 9) < 7);
      song_id = 2'($urandom_range(0, 3));
      loop_en = 1'($urandom_range(0, 1));
      run(int'($urandom_range(50, 1500)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
